unidade_controle: RTL and testbench
===================================

Name: unidade_controle

Overview:
- Multicycle control FSM that sequences the RV64 datapath: BancoRegistradores, MemoryData, ULA, ULAPC/ProgramCounter, RegistradorInstrucao and the imediato converters.
- Decodes opcode/funct3/funct7 from the instruction register and drives every datapath enable and mux select, one Moore state per phase.
- Adds a memory ready handshake with timeout, a sticky error/halt state and a retired-instruction counter.

Parameters:
- ESPERA_MAX, 15: maximum cycles spent in MEMORIA without mem_pronto before a timeout error; legal range 1..255.
- LARGURA_CONT, 32: width of contador_instr.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from RegistradorInstrucao.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30]; selects sub for add_sub.
- flag_igual  in  1  ULA flag.
- flag_menor  in  1  ULA flag.
- flag_maior_igual_u  in  1  ULA flag.
- mem_pronto  in  1  data memory ready/ack.
- carrega_ir  out  1  RegistradorInstrucao load.
- carrega_pc  out  1  ProgramCounter load.
- escolhe_constantePC  out  1  1: PC <= PC + constantePC; 0: PC <= PC + 4.
- sel_pc_alvo  out  1  1: PC <= doutULA & ~1 (jalr).
- sel_constantePC  out  1  0: imediato_B; 1: imediato_J.
- WeR  out  1  register file write.
- WeM  out  1  data memory write.
- req_mem  out  1  data memory request.
- sel_dinR  out  2  0: doutULA; 1: doutM; 2: PC+4; 3: reserved (never driven).
- sel_ula_a  out  1  0: douta; 1: PC.
- imediato  out  1  ULA B operand = constante.
- sel_imediato  out  3  0: I; 1: S; 2: B; 3: J; 4: U.
- soma_ou_subtrai  out  1  ULA add/sub enable.
- subtraindo  out  1  ULA subtract.
- estado_atual  out  3  current state encoding.
- causa_erro  out  2  00: none; 01: illegal opcode; 10: memory timeout; 11: illegal branch funct3.
- contador_instr  out  LARGURA_CONT  retired instructions.

Behaviour:
- Clock and reset:
  - Single clock `clk`; `reset` is synchronous and active-high.
  - On reset: state = BUSCA, causa_erro = 00, contador_instr = 0, memory wait counter = 0.
  - Every output is the state decode of BUSCA with no instruction loaded, so only carrega_ir = 1 and all others = 0.
  - Reset wins over every other event, including mid-MEMORIA and PARADO.
- Output timing: all outputs are combinational from the registered state plus opcode/funct3/flags (Moore-plus-decode). Any output not listed for a state is 0.
- States (encoding 0-5):
  - BUSCA(0): carrega_ir = 1. Next state is DECODIFICA.
  - DECODIFICA(1): register read settles, no enables. Next state:
    - EXECUTA for lw, sw, add_sub, addi, branch, jal, jalr, auipc.
    - PARADO with causa_erro = 01 for any other opcode.
    - PARADO with causa_erro = 11 for branch with funct3 = 010 or 011.
  - EXECUTA(2): soma_ou_subtrai = 1 for every opcode.
    - lw, addi: imediato = 1, sel_imediato = I.
    - sw: imediato = 1, sel_imediato = S.
    - add_sub: imediato = 0, subtraindo = funct7_5.
    - auipc: sel_ula_a = 1, imediato = 1, sel_imediato = U.
    - branch: subtraindo = 1, imediato = 0, carrega_pc = 1, sel_constantePC = 0, escolhe_constantePC = condition. Conditions: beq flag_igual; bne ~flag_igual; blt flag_menor; bge ~flag_menor; bltu ~flag_maior_igual_u; bgeu flag_maior_igual_u.
    - jal: WeR = 1, sel_dinR = 2, carrega_pc = 1, escolhe_constantePC = 1, sel_constantePC = 1.
    - jalr: WeR = 1, sel_dinR = 2, imediato = 1, sel_imediato = I, carrega_pc = 1, sel_pc_alvo = 1.
    - Next state: BUSCA for branch/jal/jalr; MEMORIA for lw/sw; ESCRITA otherwise.
  - MEMORIA(3): req_mem = 1; ULA controls held as in EXECUTA (address stable).
    - sw: WeM = 1 while waiting; on mem_pronto, carrega_pc = 1 and next state is BUSCA.
    - lw: on mem_pronto, next state is ESCRITA.
    - The wait counter increments each cycle without mem_pronto. Upon reaching ESPERA_MAX, next state is PARADO with causa_erro = 10.
    - mem_pronto in the same cycle the counter reaches ESPERA_MAX counts as success.
    - The counter clears on leaving MEMORIA.
  - ESCRITA(4): WeR = 1, carrega_pc = 1 (PC + 4).
    - lw: sel_dinR = 1.
    - Otherwise: ULA controls held, sel_dinR = 0.
    - Next state is BUSCA.
  - PARADO(5): all enables 0; causa_erro is sticky; stays until reset.
- Latency (minimum, mem_pronto immediate):
  - add_sub/addi/auipc: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jal/jalr: 3 cycles.
- PC is loaded exactly once per instruction, in its final cycle. PC+4 for link writes is therefore the pre-update value.
- contador_instr increments by 1 on every cycle with carrega_pc = 1, wrapping modulo 2^LARGURA_CONT.
- rd = x0 writes are issued normally; the register file ignores them.

Decomposition:
- Shared package pacote_riscv holds:
  - opcode constants: lw, sw, add_sub, addi, branch, jal, jalr, auipc;
  - funct3 branch constants;
  - state encodings;
  - sel_imediato, sel_dinR and causa_erro codes.
- One sub-module, decodificador_desvio: a combinational branch-condition evaluator (funct3 plus flags gives taken and valid). The FSM stays in unidade_controle.

Test Plan:
- Reset asserted 2 cycles, then released, with opcode = addi (0010011):
  - During reset, estado_atual = 0, carrega_ir = 1, contador_instr = 0.
  - After release, the sequence runs 0, 1, 2, 4, 0 with WeR = 1 only in ESCRITA and contador_instr = 1.
- add_sub with funct7_5 = 1: subtraindo = 1 in EXECUTA and ESCRITA; 4 cycles per instruction.
- lw with mem_pronto delayed 3 cycles:
  - MEMORIA lasts 4 cycles; ESCRITA has sel_dinR = 1; 8 cycles in total.
  - Repeat as sw: WeM = 1 for all 4 MEMORIA cycles and carrega_pc only in the last.
- Branches in EXECUTA:
  - beq with flag_igual = 1: escolhe_constantePC = 1 and sel_constantePC = 0.
  - bltu with flag_maior_igual_u = 1: escolhe_constantePC = 0.
  - funct3 = 010: PARADO with causa_erro = 11.
- jalr in EXECUTA: sel_dinR = 2, WeR = 1, sel_pc_alvo = 1, carrega_pc = 1; returns to BUSCA after 3 cycles.
- Error and reset cases:
  - Opcode 0000000: PARADO with causa_erro = 01, held 20 cycles.
  - sw with mem_pronto = 0 and ESPERA_MAX = 15: PARADO after 15 MEMORIA cycles with causa_erro = 10.
  - Reset mid-MEMORIA: estado_atual = 0 on the next edge.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the RV64 multicycle control unit: opcodes, branch funct3,
// FSM state encoding and the mux/error codes driven toward the datapath.
package pacote_riscv;

   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      PARADO     = 3'd5
   } estado_t;

   localparam logic [6:0] OP_LW      = 7'b0000011;
   localparam logic [6:0] OP_SW      = 7'b0100011;
   localparam logic [6:0] OP_ADD_SUB = 7'b0110011;
   localparam logic [6:0] OP_ADDI    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] DIN_ULA = 2'd0;
   localparam logic [1:0] DIN_MEM = 2'd1;
   localparam logic [1:0] DIN_PC4 = 2'd2;

   localparam logic [1:0] ERRO_NENHUM  = 2'b00;
   localparam logic [1:0] ERRO_OPCODE  = 2'b01;
   localparam logic [1:0] ERRO_TIMEOUT = 2'b10;
   localparam logic [1:0] ERRO_DESVIO  = 2'b11;

   function automatic logic opcode_valido(input logic [6:0] op);
      case (op)
         OP_LW, OP_SW, OP_ADD_SUB, OP_ADDI,
         OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC: opcode_valido = 1'b1;
         default:                             opcode_valido = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/unidade_controle_desvio.sv
// Combinational branch-condition evaluator: funct3 plus ULA flags give
// whether the branch is taken and whether funct3 names a real branch.
module decodificador_desvio
   import pacote_riscv::*;
(
   input  logic [2:0] funct3,
   input  logic       flag_igual,
   input  logic       flag_menor,
   input  logic       flag_maior_igual_u,
   output logic       tomado,
   output logic       valido
);

   // Condition select; funct3 010/011 are not branches
   always_comb begin
      tomado = 1'b0;
      valido = 1'b1;
      case (funct3)
         F3_BEQ:  tomado = flag_igual;
         F3_BNE:  tomado = ~flag_igual;
         F3_BLT:  tomado = flag_menor;
         F3_BGE:  tomado = ~flag_menor;
         F3_BLTU: tomado = ~flag_maior_igual_u;
         F3_BGEU: tomado = flag_maior_igual_u;
         default: begin
            tomado = 1'b0;
            valido = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the RV64 datapath: one Moore state per phase,
// memory handshake with timeout, sticky error halt and retired-instruction count.
module unidade_controle
   import pacote_riscv::*;
#(
   parameter int ESPERA_MAX   = 15,
   parameter int LARGURA_CONT = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              opcode,
   input  logic [2:0]              funct3,
   input  logic                    funct7_5,
   input  logic                    flag_igual,
   input  logic                    flag_menor,
   input  logic                    flag_maior_igual_u,
   input  logic                    mem_pronto,
   output logic                    carrega_ir,
   output logic                    carrega_pc,
   output logic                    escolhe_constantePC,
   output logic                    sel_pc_alvo,
   output logic                    sel_constantePC,
   output logic                    WeR,
   output logic                    WeM,
   output logic                    req_mem,
   output logic [1:0]              sel_dinR,
   output logic                    sel_ula_a,
   output logic                    imediato,
   output logic [2:0]              sel_imediato,
   output logic                    soma_ou_subtrai,
   output logic                    subtraindo,
   output logic [2:0]              estado_atual,
   output logic [1:0]              causa_erro,
   output logic [LARGURA_CONT-1:0] contador_instr
);

   localparam logic [7:0] ESPERA_LIM = 8'(ESPERA_MAX - 1);

   estado_t                 estado_r, proximo_s;
   logic [1:0]              causa_erro_r, erro_prox_s;
   logic [LARGURA_CONT-1:0] contador_r;
   logic [7:0]              espera_r;
   logic                    desvio_tomado_s, desvio_valido_s;
   logic                    ula_imediato_s, ula_sub_s, ula_sel_a_s;
   logic [2:0]              ula_sel_imm_s;

   decodificador_desvio u_desvio (
      .funct3             (funct3),
      .flag_igual         (flag_igual),
      .flag_menor         (flag_menor),
      .flag_maior_igual_u (flag_maior_igual_u),
      .tomado             (desvio_tomado_s),
      .valido             (desvio_valido_s)
   );

   // ULA operand/operation decode, reused by every state that keeps the ULA busy
   always_comb begin
      ula_imediato_s = 1'b0;
      ula_sel_imm_s  = IMM_I;
      ula_sub_s      = 1'b0;
      ula_sel_a_s    = 1'b0;
      case (opcode)
         OP_LW, OP_ADDI, OP_JALR: ula_imediato_s = 1'b1;
         OP_SW: begin
            ula_imediato_s = 1'b1;
            ula_sel_imm_s  = IMM_S;
         end
         OP_ADD_SUB: ula_sub_s = funct7_5;
         OP_AUIPC: begin
            ula_sel_a_s    = 1'b1;
            ula_imediato_s = 1'b1;
            ula_sel_imm_s  = IMM_U;
         end
         OP_BRANCH: ula_sub_s = 1'b1;
         default:   ula_sub_s = 1'b0;
      endcase
   end

   // Next-state and output decode
   always_comb begin
      proximo_s           = estado_r;
      erro_prox_s         = causa_erro_r;
      carrega_ir          = 1'b0;
      carrega_pc          = 1'b0;
      escolhe_constantePC = 1'b0;
      sel_pc_alvo         = 1'b0;
      sel_constantePC     = 1'b0;
      WeR                 = 1'b0;
      WeM                 = 1'b0;
      req_mem             = 1'b0;
      sel_dinR            = DIN_ULA;
      sel_ula_a           = 1'b0;
      imediato            = 1'b0;
      sel_imediato        = IMM_I;
      soma_ou_subtrai     = 1'b0;
      subtraindo          = 1'b0;
      case (estado_r)
         BUSCA: begin
            carrega_ir = 1'b1;
            proximo_s  = DECODIFICA;
         end
         DECODIFICA: begin
            if (!opcode_valido(opcode)) begin
               proximo_s   = PARADO;
               erro_prox_s = ERRO_OPCODE;
            end else if (opcode == OP_BRANCH && !desvio_valido_s) begin
               proximo_s   = PARADO;
               erro_prox_s = ERRO_DESVIO;
            end else begin
               proximo_s = EXECUTA;
            end
         end
         EXECUTA: begin
            soma_ou_subtrai = 1'b1;
            imediato        = ula_imediato_s;
            sel_imediato    = ula_sel_imm_s;
            subtraindo      = ula_sub_s;
            sel_ula_a       = ula_sel_a_s;
            case (opcode)
               OP_BRANCH: begin
                  carrega_pc          = 1'b1;
                  escolhe_constantePC = desvio_tomado_s;
                  proximo_s           = BUSCA;
               end
               OP_JAL: begin
                  WeR                 = 1'b1;
                  sel_dinR            = DIN_PC4;
                  carrega_pc          = 1'b1;
                  escolhe_constantePC = 1'b1;
                  sel_constantePC     = 1'b1;
                  proximo_s           = BUSCA;
               end
               OP_JALR: begin
                  WeR         = 1'b1;
                  sel_dinR    = DIN_PC4;
                  carrega_pc  = 1'b1;
                  sel_pc_alvo = 1'b1;
                  proximo_s   = BUSCA;
               end
               OP_LW, OP_SW:                   proximo_s = MEMORIA;
               OP_ADD_SUB, OP_ADDI, OP_AUIPC: proximo_s = ESCRITA;
               default: begin
                  proximo_s   = PARADO;
                  erro_prox_s = ERRO_OPCODE;
               end
            endcase
         end
         MEMORIA: begin
            // Address stays on the ULA until the memory acknowledges
            req_mem         = 1'b1;
            soma_ou_subtrai = 1'b1;
            imediato        = ula_imediato_s;
            sel_imediato    = ula_sel_imm_s;
            subtraindo      = ula_sub_s;
            sel_ula_a       = ula_sel_a_s;
            if (opcode == OP_SW) begin
               WeM = 1'b1;
            end else begin
               WeM = 1'b0;
            end
            if (mem_pronto) begin
               if (opcode == OP_SW) begin
                  carrega_pc = 1'b1;
                  proximo_s  = BUSCA;
               end else begin
                  proximo_s = ESCRITA;
               end
            end else if (espera_r == ESPERA_LIM) begin
               proximo_s   = PARADO;
               erro_prox_s = ERRO_TIMEOUT;
            end else begin
               proximo_s = MEMORIA;
            end
         end
         ESCRITA: begin
            WeR        = 1'b1;
            carrega_pc = 1'b1;
            proximo_s  = BUSCA;
            if (opcode == OP_LW) begin
               sel_dinR = DIN_MEM;
            end else begin
               sel_dinR        = DIN_ULA;
               soma_ou_subtrai = 1'b1;
               imediato        = ula_imediato_s;
               sel_imediato    = ula_sel_imm_s;
               subtraindo      = ula_sub_s;
               sel_ula_a       = ula_sel_a_s;
            end
         end
         PARADO:  proximo_s = PARADO;
         default: proximo_s = PARADO;
      endcase
   end

   // State, sticky error, memory wait and retired-instruction registers
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_r     <= BUSCA;
         causa_erro_r <= ERRO_NENHUM;
         contador_r   <= '0;
         espera_r     <= 8'd0;
      end else begin
         estado_r     <= proximo_s;
         causa_erro_r <= erro_prox_s;
         if (carrega_pc) begin
            contador_r <= contador_r + LARGURA_CONT'(1);
         end
         if (estado_r == MEMORIA && proximo_s == MEMORIA) begin
            espera_r <= espera_r + 8'd1;
         end else begin
            espera_r <= 8'd0;
         end
      end
   end

   assign estado_atual   = estado_r;
   assign causa_erro     = causa_erro_r;
   assign contador_instr = contador_r;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: per-cycle expected control words are
// queued per scenario and popped/compared as the FSM steps.
module tb_unidade_controle;
   import pacote_riscv::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        funct7_5 = 1'b0;
   logic        flag_igual = 1'b0, flag_menor = 1'b0, flag_maior_igual_u = 1'b0;
   logic        mem_pronto = 1'b0;
   logic        carrega_ir, carrega_pc, escolhe_constantePC, sel_pc_alvo, sel_constantePC;
   logic        WeR, WeM, req_mem, sel_ula_a, imediato, soma_ou_subtrai, subtraindo;
   logic [1:0]  sel_dinR, causa_erro;
   logic [2:0]  sel_imediato, estado_atual;
   logic [31:0] contador_instr;

   int n_aval = 0;
   int n_falhas = 0;
   logic [15:0] fila[$];
   logic [5:0]  fila_ula[$];
   logic [15:0] obs;
   logic [5:0]  obs_ula;

   always #5 clk = ~clk;

   unidade_controle #(.ESPERA_MAX(15), .LARGURA_CONT(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .flag_igual(flag_igual), .flag_menor(flag_menor), .flag_maior_igual_u(flag_maior_igual_u),
      .mem_pronto(mem_pronto), .carrega_ir(carrega_ir), .carrega_pc(carrega_pc),
      .escolhe_constantePC(escolhe_constantePC), .sel_pc_alvo(sel_pc_alvo),
      .sel_constantePC(sel_constantePC), .WeR(WeR), .WeM(WeM), .req_mem(req_mem),
      .sel_dinR(sel_dinR), .sel_ula_a(sel_ula_a), .imediato(imediato),
      .sel_imediato(sel_imediato), .soma_ou_subtrai(soma_ou_subtrai), .subtraindo(subtraindo),
      .estado_atual(estado_atual), .causa_erro(causa_erro), .contador_instr(contador_instr)
   );

   assign obs = {estado_atual, carrega_ir, carrega_pc, WeR, WeM, req_mem, sel_dinR,
                 subtraindo, escolhe_constantePC, sel_constantePC, sel_pc_alvo, causa_erro};
   assign obs_ula = {soma_ou_subtrai, imediato, sel_imediato, sel_ula_a};

   function automatic logic [15:0] r(input logic [2:0] est, input logic ir, pc, wer, wem, req,
                                     input logic [1:0] din, input logic sub, esc, selc, alvo,
                                     input logic [1:0] erro);
      return {est, ir, pc, wer, wem, req, din, sub, esc, selc, alvo, erro};
   endfunction

   localparam logic [15:0] R_B = 16'b000_1_0_0_0_0_00_0_0_0_0_00;
   localparam logic [15:0] R_D = 16'b001_0_0_0_0_0_00_0_0_0_0_00;

   task automatic test_reset();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_ADDI;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_aval++;
         if (obs !== R_B || contador_instr !== 32'd0) begin
            n_falhas++;
            $display("FAIL reset_hold: got %h cnt %0d, expected %h cnt 0", obs, contador_instr, R_B);
         end
      end
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(r(3'd4, 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(R_B);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); reset = 1'b0; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL reset_addi cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      n_aval++;
      if (contador_instr !== 32'd1) begin
         n_falhas++; $display("FAIL reset_addi_count: got %0d expected 1", contador_instr);
      end
   endtask

   task automatic test_back_to_back_sub();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_ADD_SUB; funct7_5 = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         fila.push_back(R_B); fila.push_back(R_D);
         fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0));
         fila.push_back(r(3'd4, 0, 1, 1, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0));
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); reset = 1'b0; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL sub_b2b cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      @(negedge clk); #1;
      n_aval++;
      if (contador_instr !== 32'd2) begin
         n_falhas++; $display("FAIL sub_b2b_count: got %0d expected 2", contador_instr);
      end
      funct7_5 = 1'b0;
   endtask

   task automatic test_auipc();
      logic [15:0] e;
      logic [5:0]  eu;
      reset = 1'b1; opcode = OP_AUIPC;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(r(3'd4, 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      fila_ula.push_back(6'd0); fila_ula.push_back(6'd0);
      fila_ula.push_back({1'b1, 1'b1, IMM_U, 1'b1}); fila_ula.push_back({1'b1, 1'b1, IMM_U, 1'b1});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); reset = 1'b0; #1;
         e = fila.pop_front(); eu = fila_ula.pop_front(); n_aval++;
         if (obs !== e || obs_ula !== eu) begin
            n_falhas++;
            $display("FAIL auipc cycle %0d: got %h/%h expected %h/%h", i, obs, obs_ula, e, eu);
         end
      end
   endtask

   task automatic test_lw_espera();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_LW;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      repeat (4) fila.push_back(r(3'd3, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(r(3'd4, 0, 1, 1, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0));
      fila.push_back(R_B);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); reset = 1'b0; mem_pronto = (i == 6); #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      mem_pronto = 1'b0;
      n_aval++;
      if (contador_instr !== 32'd1) begin
         n_falhas++; $display("FAIL lw_count: got %0d expected 1", contador_instr);
      end
   endtask

   task automatic test_sw_espera();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_SW;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      repeat (3) fila.push_back(r(3'd3, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(r(3'd3, 0, 1, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(R_B);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); reset = 1'b0; mem_pronto = (i == 6); #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL sw_wait cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      mem_pronto = 1'b0;
   endtask

   task automatic test_desvios();
      logic [15:0] e;
      logic [6:0]  ops[4]  = '{OP_BRANCH, OP_BRANCH, OP_JAL, OP_JALR};
      logic [2:0]  f3s[4]  = '{F3_BEQ, F3_BLTU, 3'd0, 3'd0};
      logic [2:0]  flgs[4] = '{3'b100, 3'b001, 3'b000, 3'b000};
      logic [15:0] exs[4];
      exs[0] = r(3'd2, 0, 1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0);
      exs[1] = r(3'd2, 0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0);
      exs[2] = r(3'd2, 0, 1, 1, 0, 0, 2'd2, 0, 1, 1, 0, 2'd0);
      exs[3] = r(3'd2, 0, 1, 1, 0, 0, 2'd2, 0, 0, 0, 1, 2'd0);
      for (int c = 0; c < 4; c++) begin
         reset = 1'b1; opcode = ops[c]; funct3 = f3s[c];
         {flag_igual, flag_menor, flag_maior_igual_u} = flgs[c];
         @(posedge clk);
         fila.push_back(R_B); fila.push_back(R_D); fila.push_back(exs[c]); fila.push_back(R_B);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk); reset = 1'b0; #1;
            e = fila.pop_front(); n_aval++;
            if (obs !== e) begin
               n_falhas++;
               $display("FAIL branch_jump case %0d cycle %0d: got %h expected %h", c, i, obs, e);
            end
         end
      end
      {flag_igual, flag_menor, flag_maior_igual_u} = 3'b000;
   endtask

   task automatic test_desvio_ilegal();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_BRANCH; funct3 = 3'b010;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      repeat (3) fila.push_back(r(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd3));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); reset = 1'b0; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL bad_funct3 cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      funct3 = 3'd0;
   endtask

   task automatic test_opcode_ilegal();
      logic [15:0] e;
      reset = 1'b1; opcode = 7'b0000000;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      repeat (20) fila.push_back(r(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1));
      for (int i = 0; i < 22; i++) begin
         @(negedge clk); reset = 1'b0; mem_pronto = i[0]; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL bad_opcode cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      mem_pronto = 1'b0;
      n_aval++;
      if (contador_instr !== 32'd0) begin
         n_falhas++; $display("FAIL bad_opcode_count: got %0d expected 0", contador_instr);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_SW;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      repeat (15) fila.push_back(r(3'd3, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0));
      repeat (2) fila.push_back(r(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); reset = 1'b0; mem_pronto = 1'b0; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL mem_timeout cycle %0d: got %h expected %h", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_memoria();
      logic [15:0] e;
      reset = 1'b1; opcode = OP_LW;
      @(posedge clk);
      fila.push_back(R_B); fila.push_back(R_D);
      fila.push_back(r(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0));
      repeat (3) fila.push_back(r(3'd3, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0));
      fila.push_back(R_B); fila.push_back(R_D);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); reset = (i == 5); mem_pronto = 1'b0; #1;
         e = fila.pop_front(); n_aval++;
         if (obs !== e) begin
            n_falhas++; $display("FAIL reset_in_mem cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back_sub();
      test_auipc();
      test_lw_espera();
      test_sw_espera();
      test_desvios();
      test_desvio_ilegal();
      test_opcode_ilegal();
      test_timeout();
      test_reset_memoria();
      $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
      $finish;
   end

endmodule
